vrased_reset_ctrl: RTL and testbench
====================================

# vrased_reset_ctrl

Reset sequencer for the VRASED hardware monitors. It merges the six per-monitor violation pulses into one MCU reset, holds that reset for a fixed minimum time, and releases it only once the CPU program counter reaches the reset handler. It records the first violation cause in a sticky register and keeps a saturating event count for post-mortem software. It sits between the monitor instances and the openMSP430 reset input, replacing a plain OR of the violation signals.

## Interface
- RESET_HANDLER, 16'h0000, PC value that permits reset release
- HOLD_CYCLES, 8'd16, minimum cycles reset is held before PC check; legal range 1..255
- CNT_W, 8, width of violation event counter
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pc  in  16  current CPU program counter
- viol  in  6  violation inputs, one bit per monitor: [0] X_stack, [1] AC, [2] atomicity, [3] dma_AC, [4] dma_detect, [5] dma_X_stack
- cause_clr  in  1  one-cycle pulse that clears cause and cause_valid
- reset  out  1  registered reset to MCU, active-high
- busy  out  1  high whenever state is not IDLE
- cause  out  3  first recorded cause: 0 none, 1..6 = viol bit index + 1
- cause_valid  out  1  cause holds a recorded violation
- viol_cnt  out  CNT_W  count of accepted violation events, saturating

## Operation
- States: IDLE, HOLD, WAIT_PC. Encoding comes from the shared package.
- IDLE: reset=0. If any bit of viol is set:
  - go to HOLD and load hold_ctr = HOLD_CYCLES-1.
  - increment viol_cnt by 1, regardless of how many bits are set. Saturate at all-ones.
  - if cause_valid=0, capture cause = index of lowest set viol bit + 1 and set cause_valid.
- HOLD: reset=1. hold_ctr decrements each cycle. When hold_ctr==0, go to WAIT_PC.
- WAIT_PC: reset=1. If pc==RESET_HANDLER, go to IDLE.
- Violations while in HOLD or WAIT_PC are ignored: no count, no cause update, no timer restart.
- Cause is sticky: later violations never overwrite it until cause_clr.
- cause_clr clears cause and cause_valid in any state. It does not clear viol_cnt.
- cause_clr and a capturing violation in the same IDLE cycle: the new capture wins, giving cause_valid=1 with the new cause.
- rst: state=IDLE, hold_ctr=0, reset=0, busy=0, cause=0, cause_valid=0, viol_cnt=0.
- rst mid-sequence aborts the sequence immediately at the next edge.

## Timing
- Violation sampled on edge N gives reset=1 and busy=1 from edge N onward, so reset rises one cycle after viol is presented.
- HOLD lasts exactly HOLD_CYCLES cycles. WAIT_PC lasts at least 1 cycle.
- If pc==RESET_HANDLER is sampled on edge M while in WAIT_PC, reset=0 after edge M.
- Minimum reset width is HOLD_CYCLES+1 cycles.
- A viol pulse in the first cycle back in IDLE is accepted normally. Back-to-back sequences are therefore legal.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package vrased_pkg holds:
  - state encoding constants ST_IDLE, ST_HOLD, ST_WAIT_PC.
  - cause codes CAUSE_NONE=0, CAUSE_X_STACK=1, CAUSE_AC=2, CAUSE_ATOMICITY=3, CAUSE_DMA_AC=4, CAUSE_DMA_DETECT=5, CAUSE_DMA_X_STACK=6.
  - NUM_MONITORS=6.
- One sub-module, vrased_viol_enc: combinational lowest-index priority encoder from viol[5:0] to a 3-bit cause code plus an any flag.
- Integration: the top-level vrased block instantiates this controller in place of its reset OR. The viol bit order must match the list above.

## Test plan
- **Single violation:** after rst, pulse viol=6'b000100 for one cycle with pc≠0 held for 40 cycles, then pc=0.
  - reset rises the next cycle and stays high 16 HOLD cycles plus the WAIT cycles.
  - reset falls one cycle after pc=0 is sampled.
  - cause=3, cause_valid=1, viol_cnt=1.
- **Simultaneous bits:** viol=6'b101010 in one cycle -> cause=2, viol_cnt=1.
- **Sticky and ignored events:**
  - viol[5] pulsed during HOLD and during WAIT_PC -> viol_cnt unchanged and cause unchanged.
  - second sequence with viol[0] after return to IDLE -> viol_cnt=2 and cause still 3.
- **Clear collision:** cause_clr and viol[4] in the same IDLE cycle -> cause=5, cause_valid=1. cause_clr alone afterwards -> cause=0, cause_valid=0, viol_cnt unchanged.
- **Reset mid-sequence and saturation:**
  - rst asserted in HOLD cycle 5 -> all outputs 0 after the next edge.
  - 260 sequences -> viol_cnt saturates at 255.
- **Short hold:** HOLD_CYCLES=1 with pc already 0 -> reset high for exactly 2 cycles.

Source files
------------

// File: rtl/vrased_pkg.sv
// Shared definitions for the VRASED reset sequencer: FSM encoding, cause codes
// and monitor count.
package vrased_pkg;

    localparam int NUM_MONITORS = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_WAIT_PC = 2'd2
    } state_t;

    localparam logic [2:0] CAUSE_NONE        = 3'd0;
    localparam logic [2:0] CAUSE_X_STACK     = 3'd1;
    localparam logic [2:0] CAUSE_AC          = 3'd2;
    localparam logic [2:0] CAUSE_ATOMICITY   = 3'd3;
    localparam logic [2:0] CAUSE_DMA_AC      = 3'd4;
    localparam logic [2:0] CAUSE_DMA_DETECT  = 3'd5;
    localparam logic [2:0] CAUSE_DMA_X_STACK = 3'd6;

    // Cause code for a monitor index: codes are the bit index plus one.
    function automatic logic [2:0] cause_of(input int idx);
        return 3'(idx + 1);
    endfunction

endpackage

// File: rtl/vrased_viol_enc.sv
// Lowest-index priority encoder: maps the monitor violation vector to a cause
// code and an any-violation flag. Purely combinational.
module vrased_viol_enc
    import vrased_pkg::*;
(
    input  logic [NUM_MONITORS-1:0] viol,
    output logic [2:0]              cause,
    output logic                    any
);

    logic [NUM_MONITORS:0]   clear_below;
    logic [NUM_MONITORS-1:0] hit;

    assign clear_below[0] = 1'b1;

    // A bit wins only if every lower-index bit is clear, so at most one hit is set.
    generate
        for (genvar gi = 0; gi < NUM_MONITORS; gi++) begin : g_prio
            assign clear_below[gi+1] = clear_below[gi] & ~viol[gi];
            assign hit[gi]           = viol[gi] & clear_below[gi];
        end
    endgenerate

    always_comb begin
        cause = CAUSE_NONE;
        for (int i = 0; i < NUM_MONITORS; i++) begin
            if (hit[i]) begin
                cause = cause_of(i);
            end
        end
    end

    assign any = |viol;

endmodule

// File: rtl/vrased_reset_ctrl.sv
// VRASED reset sequencer: merges monitor violations into one held MCU reset,
// released once the PC reaches the reset handler; records first cause and count.
module vrased_reset_ctrl
    import vrased_pkg::*;
#(
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter logic [7:0]  HOLD_CYCLES   = 8'd16,
    parameter int          CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             pc,
    input  logic [NUM_MONITORS-1:0] viol,
    input  logic                    cause_clr,
    output logic                    reset,
    output logic                    busy,
    output logic [2:0]              cause,
    output logic                    cause_valid,
    output logic [CNT_W-1:0]        viol_cnt
);

    state_t           state_reg, state_next;
    logic [7:0]       hold_ctr_reg, hold_ctr_next;
    logic             reset_reg, reset_next;
    logic [2:0]       cause_reg, cause_next;
    logic             cause_valid_reg, cause_valid_next;
    logic [CNT_W-1:0] viol_cnt_reg, viol_cnt_next;

    logic [2:0] enc_cause;
    logic       enc_any;

    vrased_viol_enc u_viol_enc (
        .viol  (viol),
        .cause (enc_cause),
        .any   (enc_any)
    );

    always_comb begin
        state_next       = state_reg;
        hold_ctr_next    = hold_ctr_reg;
        cause_next       = cause_reg;
        cause_valid_next = cause_valid_reg;
        viol_cnt_next    = viol_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (enc_any) begin
                    state_next    = ST_HOLD;
                    hold_ctr_next = HOLD_CYCLES - 8'd1;
                    if (viol_cnt_reg != '1) begin
                        viol_cnt_next = viol_cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (hold_ctr_reg == 8'd0) begin
                    state_next = ST_WAIT_PC;
                end else begin
                    hold_ctr_next = hold_ctr_reg - 8'd1;
                end
            end
            ST_WAIT_PC: begin
                if (pc == RESET_HANDLER) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (cause_clr) begin
            cause_next       = CAUSE_NONE;
            cause_valid_next = 1'b0;
        end
        // A clear in the same cycle frees the slot, so the new violation is recorded.
        if (state_reg == ST_IDLE && enc_any && (!cause_valid_reg || cause_clr)) begin
            cause_next       = enc_cause;
            cause_valid_next = 1'b1;
        end

        reset_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            hold_ctr_reg    <= 8'd0;
            reset_reg       <= 1'b0;
            cause_reg       <= CAUSE_NONE;
            cause_valid_reg <= 1'b0;
            viol_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            hold_ctr_reg    <= hold_ctr_next;
            reset_reg       <= reset_next;
            cause_reg       <= cause_next;
            cause_valid_reg <= cause_valid_next;
            viol_cnt_reg    <= viol_cnt_next;
        end
    end

    assign reset       = reset_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign cause       = cause_reg;
    assign cause_valid = cause_valid_reg;
    assign viol_cnt    = viol_cnt_reg;

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Directed self-checking bench for vrased_reset_ctrl (default hold and a
// one-cycle-hold instance).
module tb_vrased_reset_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic [5:0]  viol;
    logic        cause_clr;
    logic        reset, busy, cause_valid;
    logic [2:0]  cause;
    logic [7:0]  viol_cnt;

    logic        s_rst;
    logic [5:0]  s_viol;
    logic        s_reset, s_busy, s_cause_valid;
    logic [2:0]  s_cause;
    logic [7:0]  s_viol_cnt;

    int checks = 0;
    int errors = 0;
    int hi;

    always #5 clk = ~clk;

    vrased_reset_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .viol        (viol),
        .cause_clr   (cause_clr),
        .reset       (reset),
        .busy        (busy),
        .cause       (cause),
        .cause_valid (cause_valid),
        .viol_cnt    (viol_cnt)
    );

    vrased_reset_ctrl #(.HOLD_CYCLES(8'd1)) u_short (
        .clk         (clk),
        .rst         (s_rst),
        .pc          (16'h0000),
        .viol        (s_viol),
        .cause_clr   (1'b0),
        .reset       (s_reset),
        .busy        (s_busy),
        .cause       (s_cause),
        .cause_valid (s_cause_valid),
        .viol_cnt    (s_viol_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // Pulse a violation on the main DUT (pc held at 0) and count reset-high cycles.
    task automatic run_seq(input logic [5:0] v, output int cnt);
        @(negedge clk);
        viol = v;
        @(negedge clk);
        viol = '0;
        cnt = 0;
        while (reset && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; s_rst = 1'b1;
        pc = 16'h1234; viol = '0; cause_clr = 1'b0; s_viol = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0; s_rst = 1'b0;
        @(negedge clk);
        chk("rst_reset", reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cause", cause, 0);
        chk("rst_valid", cause_valid, 0);
        chk("rst_cnt", viol_cnt, 0);

        // Single violation with pc away from the handler for 40 cycles.
        viol = 6'b000100;
        #1 chk("no_comb_path", reset, 0);
        @(negedge clk);
        viol = '0;
        chk("single_reset_rise", reset, 1);
        chk("single_busy", busy, 1);
        chk("single_cause", cause, 3);
        chk("single_valid", cause_valid, 1);
        chk("single_cnt", viol_cnt, 1);
        hi = 1;
        for (int i = 1; i < 40; i++) begin
            viol = (i == 3 || i == 25) ? 6'b100000 : 6'b000000;
            @(negedge clk);
            if (reset) hi++;
        end
        viol = '0;
        pc = 16'h0000;
        @(negedge clk);
        chk("single_high_cycles", hi, 40);
        chk("single_reset_fall", reset, 0);
        chk("single_busy_fall", busy, 0);
        chk("ignored_cnt", viol_cnt, 1);
        chk("ignored_cause", cause, 3);

        // Back-to-back sequence with pc already at handler: minimum width 17.
        run_seq(6'b000001, hi);
        chk("second_width", hi, 17);
        chk("second_cnt", viol_cnt, 2);
        chk("second_sticky_cause", cause, 3);

        // Clear, then simultaneous bits: lowest index wins.
        cause_clr = 1'b1;
        @(negedge clk);
        cause_clr = 1'b0;
        chk("clr_cause", cause, 0);
        chk("clr_valid", cause_valid, 0);
        chk("clr_cnt", viol_cnt, 2);
        run_seq(6'b101010, hi);
        chk("simul_cause", cause, 2);
        chk("simul_cnt", viol_cnt, 3);

        // Clear and capture in the same IDLE cycle: capture wins.
        cause_clr = 1'b1;
        viol = 6'b010000;
        @(negedge clk);
        cause_clr = 1'b0;
        viol = '0;
        chk("coll_cause", cause, 5);
        chk("coll_valid", cause_valid, 1);
        chk("coll_cnt", viol_cnt, 4);
        hi = 0;
        while (busy && hi < 300) begin
            hi++;
            @(negedge clk);
        end
        chk("coll_width", hi, 17);
        cause_clr = 1'b1;
        @(negedge clk);
        cause_clr = 1'b0;
        chk("clr2_cause", cause, 0);
        chk("clr2_valid", cause_valid, 0);
        chk("clr2_cnt", viol_cnt, 4);

        // Reset in HOLD cycle 5 aborts at the next edge.
        viol = 6'b000010;
        @(negedge clk);
        viol = '0;
        chk("mid_cnt", viol_cnt, 5);
        repeat (4) @(negedge clk);
        chk("mid_in_hold", reset, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset", reset, 0);
        chk("mid_busy", busy, 0);
        chk("mid_cause", cause, 0);
        chk("mid_valid", cause_valid, 0);
        chk("mid_cnt_cleared", viol_cnt, 0);

        // Saturation over 260 sequences.
        for (int n = 1; n <= 260; n++) begin
            run_seq(6'b000001, hi);
            if (n == 254) chk("sat_254", viol_cnt, 254);
            if (n == 255) chk("sat_255", viol_cnt, 255);
        end
        chk("sat_260", viol_cnt, 255);
        chk("sat_width", hi, 17);

        // One-cycle hold with pc already at handler: reset high exactly 2 cycles.
        chk("short_rst_reset", s_reset, 0);
        s_viol = 6'b001000;
        @(negedge clk);
        s_viol = '0;
        hi = 0;
        while (s_reset && hi < 300) begin
            hi++;
            @(negedge clk);
        end
        chk("short_width", hi, 2);
        chk("short_cause", s_cause, 4);
        chk("short_cnt", s_viol_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
